// File: rtl/deserializer_pkg.sv
// Shared constants for the serial-to-parallel deserializer.
// Build option: DESERIALIZER_LSB_FIRST_EN selects LSB-first word assembly.
package deserializer_pkg;

    localparam int DATA_W_DEFAULT = 8;

    // Counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int result;
        if (width < 2) begin
            result = 1;
        end else begin
            result = $clog2(width);
        end
        return result;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(DATA_W_DEFAULT);

endpackage

// File: rtl/deser_shift_reg.sv
// Serial shift register with selectable bit order; exposes the next word value.
// Build option: DESERIALIZER_LSB_FIRST_EN shifts toward bit 0 so the first bit ends at dataout[0].
module deser_shift_reg
    import deserializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              din,
    output logic [DATA_W-1:0] word_next
);

    logic [DATA_W-1:0] sreg_r;
    logic [DATA_W-1:0] sreg_next_s;

    // Next register value with the incoming bit merged in.
    always_comb begin
        sreg_next_s = sreg_r;
`ifdef DESERIALIZER_LSB_FIRST_EN
        sreg_next_s = {din, sreg_r[DATA_W-1:1]};
`else
        sreg_next_s = {sreg_r[DATA_W-2:0], din};
`endif
    end

    // Shift only on qualified bits; gaps leave the partial word intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r <= {DATA_W{1'b0}};
        end else if (shift_en) begin
            sreg_r <= sreg_next_s;
        end else begin
            sreg_r <= sreg_r;
        end
    end

    assign word_next = sreg_next_s;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: one validOut strobe per DATA_W qualified bits.
// Build option: DESERIALIZER_LSB_FIRST_EN (see deser_shift_reg) selects LSB-first order.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              datain,
    input  logic              validIn,
    output logic [DATA_W-1:0] dataout,
    output logic              validOut
);

    localparam int CNT_W = cnt_width(DATA_W);

    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] word_next_s;
    logic              last_s;

    deser_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (validIn),
        .din       (datain),
        .word_next (word_next_s)
    );

    // The bit being sampled now completes the word.
    assign last_s = validIn && (cnt_r == CNT_W'(DATA_W - 1));

    // Bit counter and output registers; the completing edge loads the word directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            dataout  <= {DATA_W{1'b0}};
            validOut <= 1'b0;
        end else if (last_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            dataout  <= word_next_s;
            validOut <= 1'b1;
        end else if (validIn) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            dataout  <= dataout;
            validOut <= 1'b0;
        end else begin
            cnt_r    <= cnt_r;
            dataout  <= dataout;
            validOut <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus randomized traffic
// checked against a bit-queue reference model.
module tb_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         datain;
    logic         validIn;
    logic [W-1:0] dataout;
    logic         validOut;

    int checks;
    int failures;

    // reference model state
    logic         mq[$];
    logic [W-1:0] exp_dout;
    logic         exp_vld;

`ifdef DESERIALIZER_LSB_FIRST_EN
    logic [W-1:0] stream_words[4] = '{8'hD9, 8'hC6, 8'hBA, 8'hA2};
    logic [W-1:0] gap_word = 8'hD9;
    logic [W-1:0] rst_word = 8'hC6;
`else
    logic [W-1:0] stream_words[4] = '{8'h9B, 8'h63, 8'h5D, 8'h45};
    logic [W-1:0] gap_word = 8'h9B;
    logic [W-1:0] rst_word = 8'h63;
`endif

    deserializer #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .datain   (datain),
        .validIn  (validIn),
        .dataout  (dataout),
        .validOut (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        exp_dout = '0;
        exp_vld  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b);
        logic [W-1:0] w;
        exp_vld = 1'b0;
        if (v) begin
            mq.push_back(b);
            if (mq.size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) begin
`ifdef DESERIALIZER_LSB_FIRST_EN
                    w[i] = mq[i];
`else
                    w[W-1-i] = mq[i];
`endif
                end
                exp_dout = w;
                exp_vld  = 1'b1;
                mq.delete();
            end
        end
    endtask

    // drive one cycle, let the edge happen, advance the model
    task automatic drive(input logic v, input logic b);
        validIn = v;
        datain  = b;
        @(posedge clk);
        #1;
        model_step(v, b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            validIn = 1'($urandom_range(0, 1));
            datain  = i[0];
            @(posedge clk);
            #1;
            checks++;
            if (dataout !== 8'h00 || validOut !== 1'b0) begin
                failures++;
                $display("FAIL reset: dataout=%h validOut=%b expected 00 0", dataout, validOut);
            end
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        logic [31:0] pat;
        int pulses;
        int last_cyc;
        pat = 32'b1001_1011_0110_0011_0101_1101_0100_0101;
        pulses = 0;
        last_cyc = -1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, pat[31-i]);
            checks++;
            if (validOut !== exp_vld || dataout !== exp_dout) begin
                failures++;
                $display("FAIL stream_model: cyc=%0d dataout=%h validOut=%b expected %h %b",
                         i, dataout, validOut, exp_dout, exp_vld);
            end
            if (validOut === 1'b1) begin
                if (pulses < 4) begin
                    checks++;
                    if (dataout !== stream_words[pulses]) begin
                        failures++;
                        $display("FAIL stream_word: idx=%0d dataout=%h expected %h",
                                 pulses, dataout, stream_words[pulses]);
                    end
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (i - last_cyc != W) begin
                        failures++;
                        $display("FAIL stream_spacing: got %0d expected %0d", i - last_cyc, W);
                    end
                end
                last_cyc = i;
                pulses++;
            end
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL stream_pulses: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (validOut !== 1'b0 || dataout !== stream_words[3]) begin
                failures++;
                $display("FAIL idle: dataout=%h validOut=%b expected %h 0",
                         dataout, validOut, stream_words[3]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] byt;
        int pulses;
        byt = 8'h9B;
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            if (i >= 4 && i < 7) begin
                drive(1'b0, 1'($urandom_range(0, 1)));
                checks++;
                if (validOut !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_quiet: validOut=%b expected 0", validOut);
                end
            end else begin
                drive(1'b1, byt[7 - (i < 4 ? i : i - 3)]);
            end
            checks++;
            if (validOut !== exp_vld || dataout !== exp_dout) begin
                failures++;
                $display("FAIL gap_model: dataout=%h validOut=%b expected %h %b",
                         dataout, validOut, exp_dout, exp_vld);
            end
            if (validOut === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || dataout !== gap_word) begin
            failures++;
            $display("FAIL gap_word: pulses=%0d dataout=%h expected 1 %h", pulses, dataout, gap_word);
        end
    endtask

    task automatic test_midword_reset();
        logic [7:0] pre;
        logic [7:0] byt;
        int pulses;
        pre = 8'b1011_0000;
        byt = 8'h63;
        pulses = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, pre[7-i]);
        // asynchronous assertion away from any clock edge
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dataout !== 8'h00 || validOut !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: dataout=%h validOut=%b expected 00 0", dataout, validOut);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, byt[7-i]);
            checks++;
            if (validOut !== exp_vld || dataout !== exp_dout) begin
                failures++;
                $display("FAIL midrst_model: dataout=%h validOut=%b expected %h %b",
                         dataout, validOut, exp_dout, exp_vld);
            end
            if (validOut === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || dataout !== rst_word) begin
            failures++;
            $display("FAIL midrst_word: pulses=%0d dataout=%h expected 1 %h", pulses, dataout, rst_word);
        end
    endtask

    task automatic test_random();
        int pulses;
        int exp_pulses;
        pulses = 0;
        exp_pulses = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (validOut !== exp_vld || dataout !== exp_dout) begin
                failures++;
                $display("FAIL random: cyc=%0d dataout=%h validOut=%b expected %h %b",
                         i, dataout, validOut, exp_dout, exp_vld);
            end
            if (validOut === 1'b1) pulses++;
            if (exp_vld) exp_pulses++;
        end
        checks++;
        if (pulses != exp_pulses) begin
            failures++;
            $display("FAIL random_pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        validIn  = 1'b0;
        datain   = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_idle();
        test_gaps();
        test_midword_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the output word width in bits; legal values 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port datain, input, 1 bit: serial data bit, sampled on clk rise when validIn=1.
REQ-005 SHALL have port validIn, input, 1 bit: qualifies datain for the current cycle.
REQ-006 SHALL have port dataout, output, DATA_W bits: last completed parallel word, registered.
REQ-007 SHALL have port validOut, output, 1 bit: one-cycle strobe marking a new word on dataout.

Function
REQ-008 SHALL keep a DATA_W-bit shift register and a bit counter 0..DATA_W-1 of width $clog2(DATA_W).
REQ-009 SHALL, on a clk rise with validIn=1, shift datain into the shift register and increment the counter.
REQ-010 SHALL, on a clk rise with validIn=0, hold the shift register and counter unchanged (gap-tolerant; partial word retained).
REQ-011 SHALL, by default, place the first-received bit of a word at dataout[DATA_W-1] (MSB first).
REQ-012 SHALL, on the clk rise that samples bit DATA_W-1 of a word, load the completed word (including that bit) into dataout, assert validOut, and wrap the counter to 0.
REQ-013 SHALL have latency of zero extra cycles: dataout/validOut change on the same edge that captures the last bit.
REQ-014 SHALL deassert validOut on every clk rise that does not complete a word, so validOut is high exactly one cycle per word.
REQ-015 SHALL hold dataout unchanged between completions.
REQ-016 SHALL, with back-to-back validIn=1, emit one word every DATA_W cycles with no dead cycle between words.

Reset
REQ-017 SHALL, while rst_n=0, force dataout=0, validOut=0, shift register=0, counter=0, independent of clk.
REQ-018 SHALL discard any partial word when reset asserts mid-word; the first valid bit after release starts a new word.
REQ-019 SHALL sample normally from the first clk rise after rst_n goes high.

Configuration
REQ-020 SHALL support macro DESERIALIZER_LSB_FIRST_EN: when defined, first-received bit lands in dataout[0] (LSB first); when undefined, MSB-first per REQ-011. No other behaviour changes.

Structure
REQ-021 SHALL place DATA_W default value and the counter-width constant in package deserializer_pkg.
REQ-022 SHALL implement the shift register with its bit-order selection as one sub-module deser_shift_reg; counter and output registers stay in deserializer.

Verification
REQ-023 SHALL test reset: rst_n=0 with datain toggling -> dataout=0x00, validOut=0 throughout.
REQ-024 SHALL test stream: validIn=1 continuously, 32 bits 1,0,0,1,1,0,1,1, 0,1,1,0,0,0,1,1, 0,1,0,1,1,1,0,1, 0,1,0,0,0,1,0,1 -> four validOut pulses, 8 cycles apart, dataout 0x9B, 0x63, 0x5D, 0x45.
REQ-025 SHALL test gaps: first byte 1,0,0,1,1,0,1,1 with validIn=0 for 3 cycles after bit 4 -> single pulse, dataout=0x9B, no pulse during gap.
REQ-026 SHALL test mid-word reset: 5 bits sent, rst_n pulsed low, then 8 bits of 0x63 -> exactly one pulse, dataout=0x63.
REQ-027 SHALL test idle: validIn=0 for 50 cycles after last word -> validOut stays 0, dataout holds 0x45.
REQ-028 SHALL test DESERIALIZER_LSB_FIRST_EN defined, same bits as REQ-025 -> dataout=0xD9.
